// File: rtl/vqueue_reader_pkg.sv
// Shared types and constants for the video queue reader.
package vqueue_reader_pkg;

    // Word ownership: NOWORD = no word held, HOLD = a word is being sliced.
    typedef enum logic {
        ST_NOWORD = 1'b0,
        ST_HOLD   = 1'b1
    } vq_state_e;

    localparam int SLICES_16BPP = 2;
    localparam int SLICES_8BPP  = 4;
    localparam int PIXEL_W      = 16;

    // Index of the final slice in a word for the given pixel depth.
    function automatic logic [1:0] last_slice_idx(input logic bpp8);
        logic [1:0] idx_v;
        if (bpp8) begin
            idx_v = 2'(SLICES_8BPP - 1);
        end else begin
            idx_v = 2'(SLICES_16BPP - 1);
        end
        return idx_v;
    endfunction

endpackage

// File: rtl/vqueue_pixel_mux.sv
// Selects one pixel from the held 32-bit word, least-significant slice first.
module vqueue_pixel_mux
    import vqueue_reader_pkg::*;
(
    input  logic [31:0]        word,
    input  logic [1:0]         idx,
    input  logic               bpp8,
    output logic [PIXEL_W-1:0] pixel
);

    // 8 bpp picks a byte and zero-extends; 16 bpp picks a half-word by idx[0].
    always_comb begin
        pixel = 16'h0000;
        if (bpp8) begin
            case (idx)
                2'd0:    pixel = {8'h00, word[7:0]};
                2'd1:    pixel = {8'h00, word[15:8]};
                2'd2:    pixel = {8'h00, word[23:16]};
                2'd3:    pixel = {8'h00, word[31:24]};
                default: pixel = 16'h0000;
            endcase
        end else begin
            case (idx[0])
                1'b0:    pixel = word[15:0];
                1'b1:    pixel = word[31:16];
                default: pixel = 16'h0000;
            endcase
        end
    end

endmodule

// File: rtl/vqueue_reader.sv
// Reads 32-bit words from a queue and hands them out as 16 or 8 bpp pixels.
module vqueue_reader
    import vqueue_reader_pkg::*;
#(
    parameter logic BPP8_DEFAULT = 1'b0,
    parameter int   HEAD_SETTLE  = 2
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic [31:0]        Q,
    input  logic               Empty,
    output logic               RdEn,
    input  logic               PixelReq,
    input  logic               LineStart,
    input  logic               Bpp8,
    output logic [PIXEL_W-1:0] PixelOut,
    output logic               PixelValid,
    output logic               Underrun,
    input  logic               ClearUnderrun
);

    localparam int CNT_W = (HEAD_SETTLE < 1) ? 1 : $clog2(HEAD_SETTLE + 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(HEAD_SETTLE);

    vq_state_e          state_r, state_nxt_s;
    logic [1:0]         idx_r, idx_nxt_s;
    logic [31:0]        word_r, word_nxt_s;
    logic               bpp8_r;
    logic [CNT_W-1:0]   settle_cnt_r;
    logic               head_ok_s;
    logic               rd_en_s;
    logic               last_slice_s;
    logic [PIXEL_W-1:0] mux_pix_s;
    logic [PIXEL_W-1:0] pixel_out_nxt_s;
    logic               pixel_valid_nxt_s;
    logic               underrun_set_s;

    assign head_ok_s    = (settle_cnt_r == {CNT_W{1'b0}}) && !Empty;
    assign last_slice_s = (idx_r == last_slice_idx(bpp8_r));
    // The pop strobe must coincide with the capture edge, so it stays combinational.
    assign RdEn         = rd_en_s;

    vqueue_pixel_mux u_pixel_mux (
        .word  (word_r),
        .idx   (idx_r),
        .bpp8  (bpp8_r),
        .pixel (mux_pix_s)
    );

    // Next-state, capture, pop and pixel selection for the word holder.
    always_comb begin
        state_nxt_s       = state_r;
        idx_nxt_s         = idx_r;
        word_nxt_s        = word_r;
        rd_en_s           = 1'b0;
        pixel_out_nxt_s   = PixelOut;
        pixel_valid_nxt_s = 1'b0;
        underrun_set_s    = 1'b0;
        if (LineStart) begin
            // Drop any partial word; a request here is answered empty but is not an underrun.
            state_nxt_s = ST_NOWORD;
            idx_nxt_s   = 2'd0;
            if (PixelReq) begin
                pixel_out_nxt_s = 16'h0000;
            end else begin
                pixel_out_nxt_s = PixelOut;
            end
        end else begin
            case (state_r)
                ST_NOWORD: begin
                    if (PixelReq) begin
                        pixel_out_nxt_s = 16'h0000;
                        underrun_set_s  = 1'b1;
                    end else begin
                        pixel_out_nxt_s = PixelOut;
                    end
                    if (head_ok_s) begin
                        word_nxt_s  = Q;
                        idx_nxt_s   = 2'd0;
                        rd_en_s     = 1'b1;
                        state_nxt_s = ST_HOLD;
                    end else begin
                        state_nxt_s = ST_NOWORD;
                    end
                end
                ST_HOLD: begin
                    if (PixelReq) begin
                        pixel_out_nxt_s   = mux_pix_s;
                        pixel_valid_nxt_s = 1'b1;
                        if (last_slice_s) begin
                            idx_nxt_s = 2'd0;
                            if (head_ok_s) begin
                                word_nxt_s = Q;
                                rd_en_s    = 1'b1;
                            end else begin
                                state_nxt_s = ST_NOWORD;
                            end
                        end else begin
                            idx_nxt_s = idx_r + 2'd1;
                        end
                    end else begin
                        pixel_out_nxt_s = PixelOut;
                    end
                end
                default: begin
                    state_nxt_s = ST_NOWORD;
                    idx_nxt_s   = 2'd0;
                end
            endcase
        end
    end

    // Word holder state, slice index and held word.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_r <= ST_NOWORD;
            idx_r   <= 2'd0;
            word_r  <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            word_r  <= word_nxt_s;
        end
    end

    // Pixel depth latch, updated only at line start.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            bpp8_r <= BPP8_DEFAULT;
        end else if (LineStart) begin
            bpp8_r <= Bpp8;
        end else begin
            bpp8_r <= bpp8_r;
        end
    end

    // Head settle counter: restarts on a pop or while empty, counts down to zero.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            settle_cnt_r <= SETTLE_INIT;
        end else if (rd_en_s || Empty) begin
            settle_cnt_r <= SETTLE_INIT;
        end else if (settle_cnt_r != {CNT_W{1'b0}}) begin
            settle_cnt_r <= settle_cnt_r - CNT_W'(1);
        end else begin
            settle_cnt_r <= settle_cnt_r;
        end
    end

    // Registered pixel outputs, one cycle after the request.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            PixelOut   <= 16'h0000;
            PixelValid <= 1'b0;
        end else begin
            PixelOut   <= pixel_out_nxt_s;
            PixelValid <= pixel_valid_nxt_s;
        end
    end

    // Sticky underrun flag; a new underrun wins over a clear.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            Underrun <= 1'b0;
        end else if (underrun_set_s) begin
            Underrun <= 1'b1;
        end else if (ClearUnderrun) begin
            Underrun <= 1'b0;
        end else begin
            Underrun <= Underrun;
        end
    end

endmodule
